// File: rtl/jt7759_romrd.sv
// jt7759_romrd: two-line, 4-byte-per-line read cache between the ADPCM
// controller's byte ROM port and a 32-bit req/ack word memory, with an
// optional next-word prefetch after every demand fill.
module jt7759_romrd #(
   parameter int unsigned PREFETCH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 rom_cs,
   input  logic [16:0]          rom_addr,
   output logic [7:0]           rom_data,
   output logic                 rom_ok,
   output logic                 mem_req,
   output logic [14:0]          mem_addr,
   input  logic [31:0]          mem_data,
   input  logic                 mem_ack
);

   localparam int unsigned AW = 17;
   localparam int unsigned TW = 15;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;
   localparam int unsigned NL = 2;
   localparam logic        PF_EN = (PREFETCH != 0);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      PREF_CHK = 2'd2,
      PREF     = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   mem_req_q, mem_req_d;
   logic [TW-1:0]          mem_addr_q, mem_addr_d;
   logic                   vic_q, vic_d;
   logic                   mru_q, mru_d;
   logic                   flushed_q, flushed_d;
   logic [NL-1:0]          valid_q, valid_d;
   logic [NL-1:0][TW-1:0]  tag_q, tag_d;
   logic [NL-1:0][DW-1:0]  data_q, data_d;
   logic [BW-1:0]          rom_data_q, rom_data_d;
   logic                   rom_ok_q, rom_ok_d;

   logic [TW-1:0]          req_tag;
   logic                   hit0, hit1, hit, hit_line;
   logic [DW-1:0]          hit_word;
   logic [BW-1:0]          hit_byte;
   logic [TW-1:0]          ptag;
   logic                   pref_hit;
   logic                   ack_ok;
   logic                   fill_valid;

   // Lookup of the requested byte in both lines
   always_comb begin
      req_tag  = rom_addr[AW-1:2];
      hit0     = rom_cs & valid_q[0] & (tag_q[0] == req_tag);
      hit1     = rom_cs & valid_q[1] & (tag_q[1] == req_tag);
      hit      = hit0 | hit1;
      hit_line = ~hit0;
      hit_word = data_q[hit_line];
      hit_byte = BW'(hit_word >> {rom_addr[1:0], 3'b000});
   end

   // Prefetch candidate and handshake qualification
   always_comb begin
      ptag       = mem_addr_q + TW'(1);
      pref_hit   = (valid_q[0] & (tag_q[0] == ptag)) |
                   (valid_q[1] & (tag_q[1] == ptag));
      ack_ok     = mem_ack & mem_req_q;
      // A word whose fetch overlapped a flush must not be trusted
      fill_valid = ~(flush | flushed_q);
   end

   // Next-state, line updates and registered outputs
   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      vic_d      = vic_q;
      mru_d      = mru_q;
      flushed_d  = flushed_q | flush;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      rom_data_d = rom_data_q;
      rom_ok_d   = hit & ~flush;

      if (hit) begin
         rom_data_d = hit_byte;
         mru_d      = hit_line;
      end

      if (flush) begin
         valid_d = '0;
      end

      case (state_q)
         IDLE: begin
            flushed_d = 1'b0;
            if (rom_cs && !hit && !flush) begin
               state_d    = FETCH;
               mem_addr_d = req_tag;
               mem_req_d  = 1'b1;
               vic_d      = ~mru_q;
            end
         end

         FETCH: begin
            if (ack_ok) begin
               tag_d[vic_q]   = mem_addr_q;
               data_d[vic_q]  = mem_data;
               valid_d[vic_q] = fill_valid;
               mru_d          = vic_q;
               mem_req_d      = 1'b0;
               state_d        = PF_EN ? PREF_CHK : IDLE;
            end
         end

         PREF_CHK: begin
            // Skip the prefetch if the next word is already cached or a flush is pending
            if (pref_hit || flushed_q || flush) begin
               state_d = IDLE;
            end else begin
               state_d    = PREF;
               mem_addr_d = ptag;
               mem_req_d  = 1'b1;
               vic_d      = ~vic_q;
            end
         end

         PREF: begin
            if (ack_ok) begin
               tag_d[vic_q]   = mem_addr_q;
               data_d[vic_q]  = mem_data;
               valid_d[vic_q] = fill_valid;
               mem_req_d      = 1'b0;
               state_d        = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and storage registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         vic_q      <= 1'b0;
         mru_q      <= 1'b0;
         flushed_q  <= 1'b0;
         valid_q    <= '0;
         tag_q      <= '0;
         data_q     <= '0;
         rom_data_q <= '0;
         rom_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         vic_q      <= vic_d;
         mru_q      <= mru_d;
         flushed_q  <= flushed_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         rom_data_q <= rom_data_d;
         rom_ok_q   <= rom_ok_d;
      end
   end

   assign rom_data = rom_data_q;
   assign rom_ok   = rom_ok_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule
